// File: rtl/bram_acc_pkg.sv
// Shared definitions for the BRAM accessor: controller state encoding and
// read-side buffer sizing.
package bram_acc_pkg;

  localparam int unsigned STATE_W    = 2;
  localparam int unsigned FIFO_DEPTH = 2;

  localparam logic [STATE_W-1:0] S_IDLE = 2'b00;
  localparam logic [STATE_W-1:0] S_RUN  = 2'b01;
  localparam logic [STATE_W-1:0] S_DONE = 2'b10;

endpackage

// File: rtl/bram_rd_fifo2.sv
// Two-entry synchronous FIFO that absorbs words already in flight from the
// BRAM while the downstream consumer stalls.
module bram_rd_fifo2
  import bram_acc_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] head_data,
  output logic [1:0]        occ
);

  logic [DWIDTH-1:0] r_mem [FIFO_DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_occ;

  // When full, wr_ptr == rd_ptr: a simultaneous push/pop overwrites the slot
  // being popped, which becomes the new tail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({push, pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign head_data = r_mem[r_rd_ptr];
  assign occ       = r_occ;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && (r_occ == 2'd2)));

  a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(pop && (r_occ == 2'd0)));

endmodule

// File: rtl/bram_rd_ctrl.sv
// Read-side BRAM controller: issues addresses 0..N-1, absorbs the 1-cycle read
// latency and streams words downstream through a 2-entry buffer.
module bram_rd_ctrl
  import bram_acc_pkg::*;
#(
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic [AWIDTH:0]   num_cnt_i,
  output logic              idle_o,
  output logic              running_o,
  output logic              done_o,
  output logic [AWIDTH-1:0] addr_o,
  output logic              ce_o,
  output logic              we_o,
  input  logic [DWIDTH-1:0] q_i,
  output logic              m_valid_o,
  output logic [DWIDTH-1:0] m_data_o,
  input  logic              m_ready_i
);

  localparam int unsigned CNT_W = AWIDTH + 1;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [CNT_W-1:0]   r_num;
  logic [CNT_W-1:0]   r_issued;
  logic [CNT_W-1:0]   r_accepted;
  logic               r_inflight;
  logic [1:0]         w_occ;
  logic [DWIDTH-1:0]  w_head;
  logic               w_hs;
  logic               w_ce;
  logic               w_last_hs;

  assign w_hs      = m_valid_o && m_ready_i;
  assign w_last_hs = w_hs && (r_accepted == (r_num - CNT_W'(1)));

  // Issue only while the buffer can still hold every word already requested.
  assign w_ce = (r_state == S_RUN) && (r_issued < r_num) &&
                ((3'(w_occ) + 3'(r_inflight)) < (3'd2 + 3'(w_hs)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = (num_cnt_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last_hs) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Transfer length and progress counters; N is latched only on an accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_num      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_ce;
      if ((r_state == S_IDLE) && start_i) begin
        r_num      <= num_cnt_i;
        r_issued   <= '0;
        r_accepted <= '0;
      end else begin
        if (w_ce) begin
          r_issued <= r_issued + CNT_W'(1);
        end
        if (w_hs) begin
          r_accepted <= r_accepted + CNT_W'(1);
        end
      end
    end
  end

  bram_rd_fifo2 #(
    .DWIDTH(DWIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (r_inflight),
    .push_data(q_i),
    .pop      (w_hs),
    .head_data(w_head),
    .occ      (w_occ)
  );

  assign idle_o    = (r_state == S_IDLE);
  assign running_o = (r_state == S_RUN);
  assign done_o    = (r_state == S_DONE);
  assign addr_o    = r_issued[AWIDTH-1:0];
  assign ce_o      = w_ce;
  assign we_o      = 1'b0;
  assign m_valid_o = (w_occ != 2'd0);
  assign m_data_o  = w_head;

endmodule

// File: tb/tb_bram_rd_ctrl.sv
// Self-checking bench for bram_rd_ctrl: a BRAM model with 1-cycle read latency
// and a word-stream reference model driven by random backpressure.
module tb_bram_rd_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = AW + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] num_cnt_i = '0;
  logic          idle_o, running_o, done_o, ce_o, we_o, m_valid_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] q_i = '0;
  logic [DW-1:0] m_data_o;
  logic          m_ready_i = 1'b0;

  logic [DW-1:0] mem [256];
  int vectors = 0;
  int errs    = 0;

  bram_rd_ctrl #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (start_i),
    .num_cnt_i(num_cnt_i),
    .idle_o   (idle_o),
    .running_o(running_o),
    .done_o   (done_o),
    .addr_o   (addr_o),
    .ce_o     (ce_o),
    .we_o     (we_o),
    .q_i      (q_i),
    .m_valid_o(m_valid_o),
    .m_data_o (m_data_o),
    .m_ready_i(m_ready_i)
  );

  always #5 clk = ~clk;

  // BRAM: data valid one cycle after ce_o, garbage otherwise.
  always @(posedge clk) q_i <= ce_o ? mem[addr_o] : DW'($urandom);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    vectors++; if (idle_o !== 1'b1)    begin errs++; $display("FAIL %s idle_o got %b exp 1", tag, idle_o); end
    vectors++; if (running_o !== 1'b0) begin errs++; $display("FAIL %s running_o got %b exp 0", tag, running_o); end
    vectors++; if (done_o !== 1'b0)    begin errs++; $display("FAIL %s done_o got %b exp 0", tag, done_o); end
    vectors++; if (addr_o !== '0)      begin errs++; $display("FAIL %s addr_o got %h exp 0", tag, addr_o); end
    vectors++; if (ce_o !== 1'b0)      begin errs++; $display("FAIL %s ce_o got %b exp 0", tag, ce_o); end
    vectors++; if (we_o !== 1'b0)      begin errs++; $display("FAIL %s we_o got %b exp 0", tag, we_o); end
    vectors++; if (m_valid_o !== 1'b0) begin errs++; $display("FAIL %s m_valid_o got %b exp 0", tag, m_valid_o); end
    vectors++; if (m_data_o !== '0)    begin errs++; $display("FAIL %s m_data_o got %h exp 0", tag, m_data_o); end
  endtask

  // One complete transfer of n words. mode 0: ready held high, 1: ready low in
  // cycles 3-8, 2: random ready. inject pulses start_i in RUN and in DONE.
  task automatic run_transfer(input int n, input int mode, input bit inject);
    int c, issued, acc, acc_prev, exp_done_c, budget;
    bit prev_stall;
    logic [DW-1:0] prev_data;
    issued = 0; acc = 0; prev_stall = 1'b0; prev_data = '0;
    exp_done_c = (n == 0) ? 1 : (1 << 30);
    budget = 8 * n + 40;
    tick();
    start_i = 1'b1; num_cnt_i = CW'(n); m_ready_i = (mode != 1);
    #1;
    vectors++;
    if (idle_o !== 1'b1 || ce_o !== 1'b0) begin
      errs++; $display("FAIL start_cycle n=%0d idle_o=%b ce_o=%b exp idle 1 ce 0", n, idle_o, ce_o);
    end
    c = 0;
    while (c < exp_done_c + 2) begin
      c++;
      if (c > budget) begin
        vectors++; errs++;
        $display("FAIL timeout n=%0d accepted %0d of %0d words", n, acc, n);
        break;
      end
      tick();
      start_i   = inject && (n > 2) && ((c == 2) || (c == exp_done_c));
      num_cnt_i = start_i ? CW'(7) : CW'($urandom);
      case (mode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = !(c >= 3 && c <= 8);
        default: m_ready_i = 1'($urandom_range(0, 1));
      endcase
      #1;
      acc_prev = acc;
      vectors++;
      if (idle_o !== (c > exp_done_c)) begin
        errs++; $display("FAIL idle n=%0d cyc %0d got %b exp %b", n, c, idle_o, (c > exp_done_c));
      end
      vectors++;
      if (done_o !== (c == exp_done_c)) begin
        errs++; $display("FAIL done n=%0d cyc %0d got %b exp %b", n, c, done_o, (c == exp_done_c));
      end
      vectors++;
      if (running_o !== (n > 0 && acc_prev < n)) begin
        errs++; $display("FAIL running n=%0d cyc %0d got %b exp %b", n, c, running_o, (n > 0 && acc_prev < n));
      end
      if (ce_o === 1'b1) begin
        vectors++;
        if (issued >= n || addr_o !== AW'(issued)) begin
          errs++; $display("FAIL addr n=%0d cyc %0d got %0d exp %0d (issued %0d)", n, c, addr_o, issued, issued);
        end
        issued++;
      end
      if (mode == 0 && n > 0) begin
        vectors++;
        if (ce_o !== (c >= 1 && c <= n)) begin
          errs++; $display("FAIL ce_timing n=%0d cyc %0d got %b exp %b", n, c, ce_o, (c >= 1 && c <= n));
        end
        vectors++;
        if (m_valid_o !== (c >= 3 && c <= n + 2)) begin
          errs++; $display("FAIL valid_timing n=%0d cyc %0d got %b exp %b", n, c, m_valid_o, (c >= 3 && c <= n + 2));
        end
      end
      if (mode == 1 && c == 8) begin
        vectors++;
        if (issued != 2) begin
          errs++; $display("FAIL stall_issue reads by cyc 8 got %0d exp 2", issued);
        end
      end
      if (prev_stall) begin
        vectors++;
        if (m_valid_o !== 1'b1 || m_data_o !== prev_data) begin
          errs++; $display("FAIL hold cyc %0d valid %b data %h exp valid 1 data %h", c, m_valid_o, m_data_o, prev_data);
        end
      end
      if (m_valid_o === 1'b1 && m_ready_i) begin
        vectors++;
        if (acc >= n) begin
          errs++; $display("FAIL extra_word cyc %0d got %h exp no word", c, m_data_o);
        end else if (m_data_o !== mem[acc]) begin
          errs++; $display("FAIL data word %0d got %h exp %h", acc, m_data_o, mem[acc]);
        end
        acc++;
        if (acc == n) exp_done_c = c + 1;
      end
      prev_stall = (m_valid_o === 1'b1) && !m_ready_i;
      prev_data  = m_data_o;
    end
    start_i = 1'b0;
    vectors++;
    if (issued != n || acc != n) begin
      errs++; $display("FAIL totals n=%0d issued %0d accepted %0d exp %0d each", n, issued, acc, n);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    check_reset_values("reset");
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int k = 0; k < 256; k++) mem[k] = DW'(32'h100 + k);
    run_transfer(4, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_transfer(4, 1, 1'b0);
  endtask

  task automatic test_zero();
    run_transfer(0, 0, 1'b0);
  endtask

  task automatic test_full_depth();
    for (int k = 0; k < 256; k++) mem[k] = $urandom;
    run_transfer(256, 2, 1'b0);
  endtask

  task automatic test_random_lengths();
    for (int i = 0; i < 6; i++) run_transfer(int'($urandom_range(1, 20)), 2, 1'b0);
  endtask

  task automatic test_reset_abort();
    tick();
    start_i = 1'b1; num_cnt_i = CW'(10); m_ready_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start_i = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check_reset_values("abort");
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (done_o !== 1'b0 || ce_o !== 1'b0 || idle_o !== 1'b1) begin
        errs++; $display("FAIL abort_hold done %b ce %b idle %b exp 0 0 1", done_o, ce_o, idle_o);
      end
    end
    reset_n = 1'b1;
    run_transfer(2, 0, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_transfer(6, 0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_zero();
    test_full_depth();
    test_random_lengths();
    test_reset_abort();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/bram_rd_ctrl.md
Name: bram_rd_ctrl

Overview:
- Read-side controller for the BRAM accessor.
- On a start pulse it generates sequential BRAM read addresses 0..N-1 and absorbs the fixed 1-cycle BRAM read latency.
- It streams the read words downstream over a valid/ready handshake, with a 2-entry buffer so backpressure never loses data.
- It sits between the single-port BRAM (read port) and the downstream consumer, and reports idle/running/done to the top-level control.

Parameters:
- AWIDTH, 8, BRAM address width; the BRAM depth is 2^AWIDTH.
- DWIDTH, 32, BRAM data width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- num_cnt_i  in  AWIDTH+1  number of words N to read (0..2^AWIDTH); sampled with start_i.
- idle_o  out  1  high in IDLE.
- running_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse in DONE.
- addr_o  out  AWIDTH  BRAM read address.
- ce_o  out  1  BRAM read enable.
- we_o  out  1  BRAM write enable; constant 0.
- q_i  in  DWIDTH  BRAM read data, valid exactly 1 cycle after ce_o.
- m_valid_o  out  1  output word valid.
- m_data_o  out  DWIDTH  output word.
- m_ready_i  in  1  downstream ready.

Behaviour:
- Reset values: state IDLE, idle_o=1, running_o=0, done_o=0, addr_o=0, ce_o=0, we_o=0, m_valid_o=0, m_data_o=0. All counters, the in-flight flag and the buffer are cleared.
- Reset mid-operation aborts the transfer immediately: no done_o pulse, buffer contents discarded.
- FSM states:
  - IDLE -> RUN on start_i with num_cnt_i != 0; N is latched and the issue and accept counters are cleared.
  - IDLE -> DONE on start_i with num_cnt_i == 0; no reads are issued.
  - RUN -> DONE in the cycle after the N-th output handshake.
  - DONE -> IDLE unconditionally after 1 cycle.
- start_i outside IDLE is ignored; num_cnt_i changes outside the start cycle have no effect.
- Read issue rule, evaluated in RUN:
  - ce_o = (issued < N) && (occ + inflight - (m_valid_o && m_ready_i) < 2).
  - occ is the buffer occupancy (0..2); inflight is the ce_o of the previous cycle.
  - ce_o and addr_o are combinational from registered state.
- Addressing: addr_o = issued[AWIDTH-1:0]; issued increments on each ce_o.
  - N = 2^AWIDTH is legal: addresses 0..2^AWIDTH-1, no wrap beyond.
  - issued and accepted counters are AWIDTH+1 bits wide.
- Capture: when inflight=1, q_i is written into the buffer at the end of that cycle.
  - Capture and pop in the same cycle are both honoured.
  - The issue rule guarantees the buffer never overflows; overflow is a design error and must be asserted against in simulation.
- Output:
  - m_valid_o = (occ != 0); m_data_o = head entry.
  - Data is presented in address order.
  - While m_valid_o=1 and m_ready_i=0, m_data_o must stay stable.
  - A handshake increments accepted.
- Latency: the start_i edge is cycle 0.
  - First ce_o in cycle 1 with addr 0.
  - First m_valid_o in cycle 3.
  - With m_ready_i held at 1, throughput is 1 word/cycle.
  - done_o occurs in cycle N+3.
- running_o stays high until the last word has been accepted, not merely issued.

Decomposition:
- Shared package bram_acc_pkg: state encoding S_IDLE=2'b00, S_RUN=2'b01, S_DONE=2'b10.
- Sub-module bram_rd_fifo2: 2-entry synchronous FIFO.
  - Ports: clk, reset_n, push, push_data, pop, head_data, occ[1:0].
  - Simultaneous push and pop are allowed at occ 1 or 2.
  - Resets to empty.

Test Plan:
- N=4, m_ready_i=1, BRAM word k = 0x100+k, start in cycle 0 -> ce_o in cycles 1-4 with addr 0,1,2,3; m_valid_o in cycles 3-6 with data 0x100-0x103; done_o only in cycle 7; idle_o=1 from cycle 8.
- N=4, m_ready_i=0 in cycles 3-8, then 1 -> ce_o stops after 2 reads; m_data_o holds 0x100 stable; all 4 words delivered in order with no loss or duplicates; exactly one done_o pulse.
- N=0 start -> no ce_o; done_o in cycle 1; idle_o=1 in cycle 2.
- N=256 (AWIDTH=8) with random m_ready_i -> addresses 0..255 issued exactly once each; 256 words out in order; no FIFO overflow assertion.
- Reset asserted in cycle 5 of an N=10 run -> all outputs at reset values immediately; no done_o. A new start after reset with N=2 completes normally from addr 0.
- start_i pulsed during RUN and DONE -> ignored; the transfer count stays at the original N.
